// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter
// Brief    : Round-robin sharing of one sprite-row ROM read port among
//            NUM_REQ renderers, one access in flight, registered response.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 0
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_win;
    logic [1:0]           r_cnt;

    logic [c_PTR_W-1:0]   w_win;
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_next_ptr;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = c_PTR_W'(idx);
            end
        end
    end

    assign w_next_ptr = (r_win == c_PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
    assign busy       = (r_state == S_WAIT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rom_addr  <= '0;
            rsp_data  <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        rom_addr <= req_addr[w_win*ADDR_W +: ADDR_W];
                        gnt      <= c_ONE << w_win;
                        r_win    <= w_win;
                        r_cnt    <= 2'(ROM_LAT);
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Capture once the ROM has had ROM_LAT cycles on a stable address.
                    if (r_cnt == 2'd0) begin
                        rsp_data  <= rom_data;
                        rsp_valid <= c_ONE << r_win;
                        r_ptr     <= w_next_ptr;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// Directed bench for sprite_rom_arbiter: ROM_LAT=0 cycle table plus
// ROM_LAT=2 sequences and asynchronous reset during an access.
module tb_sprite_rom_arbiter;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [3:0]  rv;
        logic [15:0] data;
        logic        busy;
        logic [7:0]  addr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // ROM_LAT = 0 instance
    logic [3:0]  req0 = '0;
    logic [31:0] req_addr0 = {8'h37, 8'h21, 8'h09, 8'h04};
    logic [3:0]  gnt0, rv0;
    logic [7:0]  rom_addr0;
    logic [15:0] rom_data0, rsp_data0;
    logic        busy0;

    // ROM_LAT = 2 instance
    logic [3:0]  req2 = '0;
    logic [31:0] req_addr2 = {8'h37, 8'h21, 8'h55, 8'h07};
    logic [3:0]  gnt2, rv2;
    logic [7:0]  rom_addr2;
    logic [15:0] rom_data2, rsp_data2;
    logic        busy2;
    logic [15:0] pipe1 = '0, pipe2 = '0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [7:0] a);
        if (a == 8'd4) return 16'b0100110110110010;
        return {a, a ^ 8'hA5};
    endfunction

    always_comb rom_data0 = rom_fn(rom_addr0);

    always @(posedge clk) begin
        pipe1 <= rom_fn(rom_addr2);
        pipe2 <= pipe1;
    end
    assign rom_data2 = pipe2;

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16), .ROM_LAT(0)) u_lat0 (
        .Clk(clk), .Reset_n(rst_n), .req(req0), .req_addr(req_addr0),
        .gnt(gnt0), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .rsp_valid(rv0), .rsp_data(rsp_data0), .busy(busy0)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16), .ROM_LAT(2)) u_lat2 (
        .Clk(clk), .Reset_n(rst_n), .req(req2), .req_addr(req_addr2),
        .gnt(gnt2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .rsp_valid(rv2), .rsp_data(rsp_data2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic apply_row(input bit lat2, input vec_t v, input string tag);
        @(negedge clk);
        if (lat2) req2 = v.req; else req0 = v.req;
        @(posedge clk);
        #1;
        if (lat2) begin
            check({tag, " gnt"},  32'(gnt2),      32'(v.gnt));
            check({tag, " rv"},   32'(rv2),       32'(v.rv));
            check({tag, " data"}, 32'(rsp_data2), 32'(v.data));
            check({tag, " busy"}, 32'(busy2),     32'(v.busy));
            check({tag, " addr"}, 32'(rom_addr2), 32'(v.addr));
        end else begin
            check({tag, " gnt"},  32'(gnt0),      32'(v.gnt));
            check({tag, " rv"},   32'(rv0),       32'(v.rv));
            check({tag, " data"}, 32'(rsp_data0), 32'(v.data));
            check({tag, " busy"}, 32'(busy0),     32'(v.busy));
            check({tag, " addr"}, 32'(rom_addr0), 32'(v.addr));
        end
    endtask

    vec_t t0[30];
    vec_t t2[5];

    initial begin
        //          req      gnt      rv       data      busy  rom_addr
        t0[0]  = '{4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b0, 8'h00};
        t0[1]  = '{4'b1111, 4'b0001, 4'b0000, 16'h0000, 1'b1, 8'h04};
        t0[2]  = '{4'b1111, 4'b0000, 4'b0001, 16'h4DB2, 1'b0, 8'h04};
        t0[3]  = '{4'b1111, 4'b0010, 4'b0000, 16'h4DB2, 1'b1, 8'h09};
        t0[4]  = '{4'b1111, 4'b0000, 4'b0010, 16'h09AC, 1'b0, 8'h09};
        t0[5]  = '{4'b1111, 4'b0100, 4'b0000, 16'h09AC, 1'b1, 8'h21};
        t0[6]  = '{4'b1111, 4'b0000, 4'b0100, 16'h2184, 1'b0, 8'h21};
        t0[7]  = '{4'b1111, 4'b1000, 4'b0000, 16'h2184, 1'b1, 8'h37};
        t0[8]  = '{4'b1111, 4'b0000, 4'b1000, 16'h3792, 1'b0, 8'h37};
        t0[9]  = '{4'b1111, 4'b0001, 4'b0000, 16'h3792, 1'b1, 8'h04};
        t0[10] = '{4'b0000, 4'b0000, 4'b0001, 16'h4DB2, 1'b0, 8'h04};
        t0[11] = '{4'b0000, 4'b0000, 4'b0000, 16'h4DB2, 1'b0, 8'h04};
        t0[12] = '{4'b0010, 4'b0010, 4'b0000, 16'h4DB2, 1'b1, 8'h09};
        t0[13] = '{4'b0000, 4'b0000, 4'b0010, 16'h09AC, 1'b0, 8'h09};
        t0[14] = '{4'b1010, 4'b1000, 4'b0000, 16'h09AC, 1'b1, 8'h37};
        t0[15] = '{4'b0010, 4'b0000, 4'b1000, 16'h3792, 1'b0, 8'h37};
        t0[16] = '{4'b0010, 4'b0010, 4'b0000, 16'h3792, 1'b1, 8'h09};
        t0[17] = '{4'b0000, 4'b0000, 4'b0010, 16'h09AC, 1'b0, 8'h09};
        t0[18] = '{4'b0001, 4'b0001, 4'b0000, 16'h09AC, 1'b1, 8'h04};
        t0[19] = '{4'b0000, 4'b0000, 4'b0001, 16'h4DB2, 1'b0, 8'h04};
        t0[20] = '{4'b0000, 4'b0000, 4'b0000, 16'h4DB2, 1'b0, 8'h04};
        t0[21] = '{4'b0010, 4'b0010, 4'b0000, 16'h4DB2, 1'b1, 8'h09};
        t0[22] = '{4'b0010, 4'b0000, 4'b0010, 16'h09AC, 1'b0, 8'h09};
        t0[23] = '{4'b0010, 4'b0010, 4'b0000, 16'h09AC, 1'b1, 8'h09};
        t0[24] = '{4'b0000, 4'b0000, 4'b0010, 16'h09AC, 1'b0, 8'h09};
        t0[25] = '{4'b0010, 4'b0010, 4'b0000, 16'h09AC, 1'b1, 8'h09};
        t0[26] = '{4'b1010, 4'b0000, 4'b0010, 16'h09AC, 1'b0, 8'h09};
        t0[27] = '{4'b1010, 4'b1000, 4'b0000, 16'h09AC, 1'b1, 8'h37};
        t0[28] = '{4'b0000, 4'b0000, 4'b1000, 16'h3792, 1'b0, 8'h37};
        t0[29] = '{4'b0000, 4'b0000, 4'b0000, 16'h3792, 1'b0, 8'h37};

        // ROM_LAT=2, requester 0 at address 7
        t2[0] = '{4'b0001, 4'b0001, 4'b0000, 16'h0000, 1'b1, 8'h07};
        t2[1] = '{4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1, 8'h07};
        t2[2] = '{4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1, 8'h07};
        t2[3] = '{4'b0000, 4'b0000, 4'b0001, 16'h07A2, 1'b0, 8'h07};
        t2[4] = '{4'b0000, 4'b0000, 4'b0000, 16'h07A2, 1'b0, 8'h07};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset gnt",   32'(gnt0),      32'h0);
        check("reset rv",    32'(rv0),       32'h0);
        check("reset busy",  32'(busy0),     32'h0);
        check("reset addr",  32'(rom_addr0), 32'h0);
        check("reset data",  32'(rsp_data0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 30; k++)
            apply_row(1'b0, t0[k], $sformatf("lat0 v%0d", k));

        for (int k = 0; k < 5; k++)
            apply_row(1'b1, t2[k], $sformatf("lat2 v%0d", k));

        // Reset asserted between edges while an access is in flight
        @(negedge clk);
        req2 = 4'b0010;
        @(posedge clk);
        #1;
        check("pre-reset gnt",  32'(gnt2),      32'h2);
        check("pre-reset busy", 32'(busy2),     32'h1);
        check("pre-reset addr", 32'(rom_addr2), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("async gnt",   32'(gnt2),      32'h0);
        check("async rv",    32'(rv2),       32'h0);
        check("async busy",  32'(busy2),     32'h0);
        check("async addr",  32'(rom_addr2), 32'h0);
        check("async data",  32'(rsp_data2), 32'h0);
        check("async addr0", 32'(rom_addr0), 32'h0);
        req2 = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset rv c%0d", k),   32'(rv2),   32'h0);
            check($sformatf("post-reset busy c%0d", k), 32'(busy2), 32'h0);
        end

        // Pointer back at 0 after reset: same access sequence as before
        for (int k = 0; k < 5; k++)
            apply_row(1'b1, t2[k], $sformatf("lat2 again v%0d", k));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
